// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS frame scheduler: FSM encoding and defaults.
package lvds_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_DATA,
      S_EOF,
      S_GAP
   } state_t;

   localparam int         BYTE_CYCLES_DEF = 10;
   localparam logic [7:0] FLAG_BYTE_DEF   = 8'h7E;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer names the channel that wins a tie;
// a grant is produced only when the update strobe marks an arbitration slot.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       ptr,
   input  logic       update,
   output logic [1:0] grant
);

   // Prefer the pointed-to channel, fall back to its peer.
   always_comb begin
      grant = 2'b00;
      if (update) begin
         if (ptr) begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
         end else begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
         end
      end
   end

endmodule

// File: rtl/lvds_frame_scheduler.sv
// Frames byte packets from two requesters with 0x7E flags and feeds the LVDS
// serializer on a fixed byte-slot grid. A byte is loaded on the last cycle of
// a slot (fetch) and its start strobe lands on the first cycle of the next
// slot (issue); a busy serializer holds the grid at slot 0 until it frees up.
module lvds_frame_scheduler
   import lvds_pkg::*;
#(
   parameter int         BYTE_CYCLES = BYTE_CYCLES_DEF,
   parameter int         GAP_SLOTS   = 1,
   parameter logic [7:0] FLAG_BYTE   = FLAG_BYTE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ch0_data_i,
   input  logic       ch0_valid_i,
   input  logic       ch0_last_i,
   output logic       ch0_ready_o,
   input  logic [7:0] ch1_data_i,
   input  logic       ch1_valid_i,
   input  logic       ch1_last_i,
   output logic       ch1_ready_o,
   input  logic       ser_busy_i,
   output logic [7:0] ser_data_o,
   output logic       ser_start_o,
   output logic       ser_st_flag_o,
   output logic [1:0] grant_o,
   output logic       frame_active_o,
   output logic       underrun_o
);

   localparam int             CW        = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
   localparam logic [CW-1:0]  SLOT_LAST = CW'(BYTE_CYCLES - 1);
   localparam logic [7:0]     GAP_END   = 8'(GAP_SLOTS);

   state_t         state;
   logic [CW-1:0]  slot_cnt;
   logic           pending;
   logic           ptr;
   logic           last_q;
   logic           kind_sof;
   logic           kind_eof;
   logic [1:0]     owner;
   logic [1:0]     arb_grant;
   logic [7:0]     gap_cnt;

   logic           fetch;
   logic           gap_done;
   logic           arb_en;
   logic           in_data;
   logic           g_valid;
   logic           g_last;
   logic [7:0]     g_data;
   logic           data_fetch;
   logic           load_sof;
   logic           load_eof;
   logic           load_dat;
   logic           load;
   logic           issue_now;
   logic           sof_issue;
   logic           eof_issue;

   // A stalled byte keeps the grid parked at slot 0, so no fetch can overlap it.
   assign fetch      = (slot_cnt == SLOT_LAST) && !pending;
   assign gap_done   = (state == S_IDLE) ||
                       ((state == S_EOF) && (GAP_SLOTS == 0)) ||
                       ((state == S_GAP) && (gap_cnt >= GAP_END));
   assign arb_en     = fetch && gap_done;
   assign in_data    = (state == S_SOF) || ((state == S_DATA) && !last_q);
   assign g_valid    = owner[1] ? ch1_valid_i : ch0_valid_i;
   assign g_last     = owner[1] ? ch1_last_i  : ch0_last_i;
   assign g_data     = owner[1] ? ch1_data_i  : ch0_data_i;
   assign data_fetch = fetch && in_data;

   assign ch0_ready_o = data_fetch && owner[0] && ch0_valid_i;
   assign ch1_ready_o = data_fetch && owner[1] && ch1_valid_i;
   assign underrun_o  = data_fetch && !g_valid;

   assign load_sof  = |arb_grant;
   assign load_eof  = (fetch && (state == S_DATA) && last_q) || underrun_o;
   assign load_dat  = data_fetch && g_valid;
   assign load      = load_sof || load_eof || load_dat;
   assign issue_now = (load || pending) && !ser_busy_i;
   assign sof_issue = issue_now && (pending ? kind_sof : load_sof);
   assign eof_issue = issue_now && (pending ? kind_eof : load_eof);

   rr_arbiter_2 u_arb (
      .req    ({ch1_valid_i, ch0_valid_i}),
      .ptr    (ptr),
      .update (arb_en),
      .grant  (arb_grant)
   );

   // Slot grid: free-running count, parked at 0 while a loaded byte waits on busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt <= '0;
         pending  <= 1'b0;
      end else begin
         if (fetch)         slot_cnt <= '0;
         else if (!pending) slot_cnt <= slot_cnt + 1'b1;
         pending <= pending ? ser_busy_i : (load && ser_busy_i);
      end
   end

   // Frame sequencer: decides at each fetch what the next slot carries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         owner   <= 2'b00;
         last_q  <= 1'b0;
         gap_cnt <= 8'd0;
      end else if (fetch) begin
         case (state)
            S_IDLE, S_EOF, S_GAP: begin
               if (gap_done) begin
                  if (load_sof) begin
                     state <= S_SOF;
                     owner <= arb_grant;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (state == S_EOF) begin
                  state   <= S_GAP;
                  gap_cnt <= 8'd1;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            S_SOF, S_DATA: begin
               if (in_data) begin
                  if (g_valid) begin
                     state  <= S_DATA;
                     last_q <= g_last;
                  end else begin
                     state  <= S_EOF;
                     last_q <= 1'b0;
                  end
               end else begin
                  state  <= S_EOF;
                  last_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Serializer byte register and start strobe; data holds until the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_data_o    <= 8'h00;
         ser_st_flag_o <= 1'b0;
         ser_start_o   <= 1'b0;
         kind_sof      <= 1'b0;
         kind_eof      <= 1'b0;
      end else begin
         ser_start_o <= issue_now;
         if (load) begin
            ser_data_o    <= load_dat ? g_data : FLAG_BYTE;
            ser_st_flag_o <= !load_dat;
            kind_sof      <= load_sof;
            kind_eof      <= load_eof;
         end
      end
   end

   // Frame ownership follows the flags as they actually leave for the serializer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_o        <= 2'b00;
         frame_active_o <= 1'b0;
         ptr            <= 1'b0;
      end else if (sof_issue) begin
         grant_o        <= pending ? owner : arb_grant;
         frame_active_o <= 1'b1;
      end else if (eof_issue) begin
         grant_o        <= 2'b00;
         frame_active_o <= 1'b0;
         ptr            <= owner[0];
      end
   end

endmodule

// File: tb/tb_lvds_frame_scheduler.sv
// Bench for lvds_frame_scheduler: byte sources on both channels, a slot-level
// reference model predicting every serializer start, and a start monitor.
module tb_lvds_frame_scheduler;

   localparam int         BC   = 10;
   localparam int         GAPS = 1;
   localparam logic [7:0] FLAG = 8'h7E;

   localparam int P_IDLE    = 0;
   localparam int P_OPEN    = 1;
   localparam int P_CLOSE   = 2;
   localparam int P_CLOSING = 3;
   localparam int P_GAP     = 4;

   logic       clk;
   logic       reset;
   logic [7:0] ch0_data_i, ch1_data_i;
   logic       ch0_valid_i, ch1_valid_i, ch0_last_i, ch1_last_i;
   logic       ch0_ready_o, ch1_ready_o;
   logic       ser_busy_i;
   logic [7:0] ser_data_o;
   logic       ser_start_o, ser_st_flag_o, frame_active_o, underrun_o;
   logic [1:0] grant_o;

   lvds_frame_scheduler #(.BYTE_CYCLES(BC), .GAP_SLOTS(GAPS), .FLAG_BYTE(FLAG)) dut (
      .clk            (clk),
      .reset          (reset),
      .ch0_data_i     (ch0_data_i),
      .ch0_valid_i    (ch0_valid_i),
      .ch0_last_i     (ch0_last_i),
      .ch0_ready_o    (ch0_ready_o),
      .ch1_data_i     (ch1_data_i),
      .ch1_valid_i    (ch1_valid_i),
      .ch1_last_i     (ch1_last_i),
      .ch1_ready_o    (ch1_ready_o),
      .ser_busy_i     (ser_busy_i),
      .ser_data_o     (ser_data_o),
      .ser_start_o    (ser_start_o),
      .ser_st_flag_o  (ser_st_flag_o),
      .grant_o        (grant_o),
      .frame_active_o (frame_active_o),
      .underrun_o     (underrun_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [7:0] d; logic l; } byte_t;
   typedef struct { int due; logic [7:0] d; logic f; logic [1:0] g; logic a; } exp_t;
   typedef struct { int cyc; logic [7:0] d; logic f; logic [1:0] g; } log_t;

   byte_t src0[$];
   byte_t src1[$];
   exp_t  expq[$];
   log_t  slog[$];

   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = -1;
   bit  rand_en  = 1'b0;
   logic took0 = 1'b0, took1 = 1'b0;

   int   m_slot, m_ptr, m_owner, m_gap, phase;
   bit   m_stall;
   exp_t m_pend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_log(input string name, input int i, input int c, input logic [7:0] d,
                          input logic f, input logic [1:0] g);
      if (i < slog.size()) begin
         chk({name, "_cycle"}, 32'(slog[i].cyc), 32'(c));
         chk({name, "_data"},  32'(slog[i].d),   32'(d));
         chk({name, "_flag"},  32'(slog[i].f),   32'(f));
         chk({name, "_grant"}, 32'(slog[i].g),   32'(g));
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: start %0d missing, only %0d starts seen", name, i, slog.size());
      end
   endtask

   // Byte sources: pop on the cycle after a consumed fetch, present the queue head.
   initial forever begin
      @(negedge clk);
      took0 <= ch0_ready_o;
      took1 <= ch1_ready_o;
   end

   initial begin
      ch0_valid_i = 0; ch0_data_i = 0; ch0_last_i = 0;
      ch1_valid_i = 0; ch1_data_i = 0; ch1_last_i = 0;
      forever begin
         @(posedge clk);
         #1;
         if (took0 && src0.size() > 0) void'(src0.pop_front());
         if (took1 && src1.size() > 0) void'(src1.pop_front());
         if (src0.size() > 0 && !(rand_en && $urandom_range(7) == 0)) begin
            ch0_valid_i = 1; ch0_data_i = src0[0].d; ch0_last_i = src0[0].l;
         end else begin
            ch0_valid_i = 0; ch0_data_i = 0; ch0_last_i = 0;
         end
         if (src1.size() > 0 && !(rand_en && $urandom_range(7) == 0)) begin
            ch1_valid_i = 1; ch1_data_i = src1[0].d; ch1_last_i = src1[0].l;
         end else begin
            ch1_valid_i = 0; ch1_data_i = 0; ch1_last_i = 0;
         end
      end
   end

   // Reference model: one decision per byte slot, expected starts go to expq.
   initial forever begin
      bit    have, v, lst, exp_r0, exp_r1, exp_ur;
      exp_t  e;
      @(negedge clk);
      if (reset) begin
         cyc = -1; m_slot = 0; m_ptr = 0; m_owner = 0; m_gap = 0;
         phase = P_IDLE; m_stall = 0; expq.delete();
      end else begin
         cyc++;
         exp_r0 = 0; exp_r1 = 0; exp_ur = 0; have = 0;
         e = '{0, 8'h00, 1'b0, 2'b00, 1'b0};
         if (m_stall) begin
            if (!ser_busy_i) begin
               m_pend.due = cyc + 1;
               expq.push_back(m_pend);
               m_stall = 0;
            end
         end else if (m_slot == BC - 1) begin
            if (phase == P_CLOSING && GAPS > 0) begin
               phase = P_GAP; m_gap = 1;
            end else if (phase == P_GAP && m_gap < GAPS) begin
               m_gap++;
            end else if (phase == P_OPEN) begin
               v   = m_owner ? ch1_valid_i : ch0_valid_i;
               lst = m_owner ? ch1_last_i  : ch0_last_i;
               have = 1;
               if (v) begin
                  if (m_owner) exp_r1 = 1; else exp_r0 = 1;
                  e = '{0, (m_owner ? ch1_data_i : ch0_data_i), 1'b0,
                        (m_owner ? 2'b10 : 2'b01), 1'b1};
                  if (lst) phase = P_CLOSE;
               end else begin
                  exp_ur = 1;
                  e = '{0, FLAG, 1'b1, 2'b00, 1'b0};
                  phase = P_CLOSING; m_ptr = 1 - m_owner;
               end
            end else if (phase == P_CLOSE) begin
               have = 1;
               e = '{0, FLAG, 1'b1, 2'b00, 1'b0};
               phase = P_CLOSING; m_ptr = 1 - m_owner;
            end else begin
               if (ch0_valid_i || ch1_valid_i) begin
                  v = (m_ptr == 1) ? ch1_valid_i : ch0_valid_i;
                  m_owner = v ? m_ptr : 1 - m_ptr;
                  e = '{0, FLAG, 1'b1, (m_owner ? 2'b10 : 2'b01), 1'b1};
                  have = 1; phase = P_OPEN;
               end else begin
                  phase = P_IDLE;
               end
            end
            if (have) begin
               if (ser_busy_i) begin
                  m_stall = 1; m_pend = e;
               end else begin
                  e.due = cyc + 1;
                  expq.push_back(e);
               end
            end
            m_slot = 0;
         end else begin
            m_slot = (m_slot + 1) % BC;
         end
         chk("ch0_ready", 32'(ch0_ready_o), 32'(exp_r0));
         chk("ch1_ready", 32'(ch1_ready_o), 32'(exp_r1));
         chk("underrun",  32'(underrun_o),  32'(exp_ur));
      end
   end

   // Start monitor: every serializer start must match the oldest prediction.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (!reset) begin
         while (expq.size() > 0 && expq[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_start: no start at cycle %0d, required data %0h", expq[0].due, expq[0].d);
            void'(expq.pop_front());
         end
         if (ser_start_o) begin
            slog.push_back('{cyc, ser_data_o, ser_st_flag_o, grant_o});
            if (expq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_start: data %0h at cycle %0d, none required", ser_data_o, cyc);
            end else begin
               e = expq.pop_front();
               chk("start_cycle",  32'(cyc),            32'(e.due));
               chk("start_data",   32'(ser_data_o),     32'(e.d));
               chk("start_flag",   32'(ser_st_flag_o),  32'(e.f));
               chk("start_grant",  32'(grant_o),        32'(e.g));
               chk("start_active", 32'(frame_active_o), 32'(e.a));
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1; ser_busy_i = 0; rand_en = 0;
      src0.delete(); src1.delete();
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic release_reset();
      slog.delete();
      reset = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (!(src0.size() == 0 && src1.size() == 0 && expq.size() == 0 &&
               phase == P_IDLE && !m_stall) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      #2;
      if (n >= maxc) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_data"},   32'(ser_data_o),     32'h0);
      chk({name, "_start"},  32'(ser_start_o),    32'h0);
      chk({name, "_flag"},   32'(ser_st_flag_o),  32'h0);
      chk({name, "_grant"},  32'(grant_o),        32'h0);
      chk({name, "_active"}, 32'(frame_active_o), 32'h0);
      chk({name, "_under"},  32'(underrun_o),     32'h0);
      chk({name, "_rdy0"},   32'(ch0_ready_o),    32'h0);
      chk({name, "_rdy1"},   32'(ch1_ready_o),    32'h0);
   endtask

   initial begin
      reset = 1; ser_busy_i = 0;
      repeat (3) @(posedge clk);
      #2;
      chk_all_zero("reset");

      // Single packet on ch0.
      src0.push_back('{8'hA5, 1'b0});
      src0.push_back('{8'h3C, 1'b1});
      release_reset();
      wait_cycles(60);
      chk_log("single0", 0, 10, FLAG, 1'b1, 2'b01);
      chk_log("single1", 1, 20, 8'hA5, 1'b0, 2'b01);
      chk_log("single2", 2, 30, 8'h3C, 1'b0, 2'b01);
      chk_log("single3", 3, 40, FLAG, 1'b1, 2'b00);
      chk("single_starts", 32'(slog.size()), 32'd4);

      // Contention from reset release: ch0, ch1, ch0.
      do_reset();
      src0.push_back('{8'h11, 1'b1});
      src0.push_back('{8'h12, 1'b1});
      src1.push_back('{8'h21, 1'b1});
      release_reset();
      drain(600);
      chk_log("cont0", 0, 10, FLAG, 1'b1, 2'b01);
      chk_log("cont1", 3, 50, FLAG, 1'b1, 2'b10);
      chk_log("cont2", 4, 60, 8'h21, 1'b0, 2'b10);
      chk_log("cont3", 6, 90, FLAG, 1'b1, 2'b01);

      // Underrun on ch1 after one byte.
      do_reset();
      src1.push_back('{8'h11, 1'b0});
      release_reset();
      wait_cycles(45);
      chk_log("under0", 0, 10, FLAG, 1'b1, 2'b10);
      chk_log("under1", 1, 20, 8'h11, 1'b0, 2'b10);
      chk_log("under2", 2, 30, FLAG, 1'b1, 2'b00);

      // Busy held across the issue of the first data byte.
      do_reset();
      src0.push_back('{8'h55, 1'b0});
      src0.push_back('{8'h66, 1'b1});
      release_reset();
      repeat (19) @(posedge clk);
      #2;
      ser_busy_i = 1;
      repeat (3) @(posedge clk);
      #2;
      ser_busy_i = 0;
      wait_cycles(40);
      chk_log("busy0", 0, 10, FLAG, 1'b1, 2'b01);
      chk_log("busy1", 1, 23, 8'h55, 1'b0, 2'b01);
      chk_log("busy2", 2, 33, 8'h66, 1'b0, 2'b01);
      chk_log("busy3", 3, 43, FLAG, 1'b1, 2'b00);

      // Reset in the middle of a frame, then a fresh request on ch1.
      do_reset();
      src0.push_back('{8'hA1, 1'b0});
      src0.push_back('{8'hA2, 1'b0});
      src0.push_back('{8'hA3, 1'b1});
      release_reset();
      repeat (25) @(posedge clk);
      #1;
      chk("pre_reset_active", 32'(frame_active_o), 32'd1);
      chk("pre_reset_data",   32'(ser_data_o),     32'hA1);
      #1;
      reset = 1;
      #1;
      chk_all_zero("async_reset");
      src0.delete();
      src1.delete();
      src1.push_back('{8'hB7, 1'b1});
      repeat (2) @(posedge clk);
      #2;
      release_reset();
      wait_cycles(45);
      chk_log("rst0", 0, 10, FLAG, 1'b1, 2'b10);
      chk_log("rst1", 1, 20, 8'hB7, 1'b0, 2'b10);
      chk_log("rst2", 2, 30, FLAG, 1'b1, 2'b00);

      // Back-to-back one-byte packets on ch0.
      do_reset();
      src0.push_back('{8'hC1, 1'b1});
      src0.push_back('{8'hC2, 1'b1});
      src0.push_back('{8'hC3, 1'b1});
      release_reset();
      drain(400);
      chk_log("b2b0", 0, 10, FLAG, 1'b1, 2'b01);
      chk_log("b2b1", 1, 20, 8'hC1, 1'b0, 2'b01);
      chk_log("b2b2", 2, 30, FLAG, 1'b1, 2'b00);
      chk_log("b2b3", 3, 50, FLAG, 1'b1, 2'b01);
      chk_log("b2b4", 4, 60, 8'hC2, 1'b0, 2'b01);
      chk_log("b2b5", 6, 90, FLAG, 1'b1, 2'b01);

      // Randomized traffic with valid dropouts and busy pulses.
      do_reset();
      release_reset();
      rand_en = 1;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk);
         #2;
         ser_busy_i = ($urandom_range(15) == 0);
         if (src0.size() < 3 && $urandom_range(15) == 0) begin
            int len = $urandom_range(4, 1);
            for (int k = 0; k < len; k++)
               src0.push_back('{8'($urandom_range(255)), (k == len - 1)});
         end
         if (src1.size() < 3 && $urandom_range(15) == 0) begin
            int len = $urandom_range(4, 1);
            for (int k = 0; k < len; k++)
               src1.push_back('{8'($urandom_range(255)), (k == len - 1)});
         end
      end
      @(posedge clk);
      #2;
      rand_en = 0;
      ser_busy_i = 0;
      drain(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
